rgb_pwm: RTL and testbench
==========================

Name: rgb_pwm

Overview:
- Three-channel LED PWM generator and bus slave. Sits between the system core's peripheral bus and the on-chip RGB LED current driver, and produces the three PWM enable lines the driver consumes.
- It replaces the static GPIO bits now used for the LED with 8-bit duty control per channel. It also offers an optional hardware "breathing" fade, so the CPU does not need to bit-bang.

Parameters:
- PRE_RST, 16'd0, reset value of the prescaler register.
- BSTEP_RST, 16'd0, reset value of the breathe-step register.

Ports:
- clk  input  1  system clock (24 MHz)
- reset_n  input  1  synchronous reset, active-low
- cs  input  1  bus chip select for this block
- we  input  1  write strobe, qualified by cs
- addr  input  3  register address
- din  input  32  write data
- dout  output  32  read data
- pwm  output  3  PWM drive: [0] to RGB0PWM, [1] to RGB1PWM, [2] to RGB2PWM

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is sampled only on the rising edge of clk while reset_n==0.
  - Reset values: all registers cleared, except PRE=PRE_RST and BSTEP=BSTEP_RST. dout=0, pwm=3'b000, all counters=0, breathe level=0, breathe direction=up.
- Register map (addr):
  - 0 CTRL: [0] EN, [1] BREATHE. Other bits read as 0.
  - 1 PRE[15:0]: one PWM tick every PRE+1 clocks.
  - 2 DUTY0[7:0], 3 DUTY1[7:0], 4 DUTY2[7:0].
  - 5 BSTEP[15:0]: breathe level advances once every BSTEP+1 PWM periods.
  - 6 STATUS (read-only): [7:0] current breathe level, [8] direction (1=down), [9] period-start flag.
    - The period-start flag is sticky. It clears on a read of addr 6.
    - If a clear and a set fall on the same cycle, the set wins.
  - 7 reads 0.
  - Writes to addresses 6 and 7 are ignored.
  - Register widths are zero-extended on read. Unused din bits are ignored.
- Bus timing:
  - Write: takes effect on the clk edge where cs&we. The new value is visible in the register the next cycle.
  - Read: on cs&!we, dout is registered and valid one cycle later. dout holds its value until the next read.
- Prescaler:
  - 16-bit counter, runs only while EN=1.
  - tick asserts for one clock when the counter equals PRE. The counter returns to 0 on that clock.
  - PRE=0 gives a tick every clock.
- PWM counter:
  - 8-bit, increments on tick, wraps 255->0. One period = 256 ticks.
  - Period start: the counter reaches 0 on a tick.
- Duty shadowing:
  - Each channel's effective duty (EFF) is latched only at period start, and also when EN goes 0->1.
  - A DUTY write mid-period therefore never affects the current period. This rule makes the output glitch-free.
- EFF calculation:
  - BREATHE=0: EFF=DUTY.
  - BREATHE=1: EFF=(DUTY*level)[15:8]. The product is 16-bit unsigned, truncated; there is no rounding.
- Output:
  - pwm[n] is registered. pwm[n]=1 when count < EFF[n].
  - EFF=0 gives a constant 0. EFF=255 gives 255/256 high; the output is never constantly high.
- Breathe engine:
  - A 16-bit period counter increments at each period start. When it equals BSTEP, it resets and the level steps by 1 in the current direction.
  - At level 255 while going up, the direction flips to down; the next step gives 254. At level 0 while going down, the direction flips to up.
  - Level and direction hold while BREATHE=0.
- EN=0:
  - Prescaler, PWM counter and breathe period counter are held at 0, and pwm=0 from the next clock.
  - Registers keep their values; level and direction keep their values.
- EN 0->1: counting starts from 0 on the following clock, and EFF is latched that same clock.
- Reset asserted mid-period: all outputs are 0 on the next clock, regardless of cs/we.
- Simultaneous DUTY write and period start: EFF latches the old DUTY. The new DUTY applies from the following period.

Test Plan:
- Reset check: drive reset_n=0 for 2 clocks, then read all 8 addresses -> pwm=000 during and after reset. Addr 1 and 5 read PRE_RST and BSTEP_RST; every other address reads 0. Each read is valid 1 clock after cs.
- Basic duty: PRE=0, DUTY0=64, DUTY1=0, DUTY2=255, CTRL=1 -> per 256-clock period, pwm[0] high exactly 64 clocks starting at count 0. pwm[1] never high. pwm[2] high 255 clocks, low 1 clock.
- Prescaler: PRE=3, DUTY0=128 -> period is 1024 clocks; pwm[0] high for 512 consecutive clocks.
- Glitch-free update: write DUTY0=200 at count 100 while DUTY0=50 -> the current period still shows 50 ticks high. The next period shows 200. Repeat with the write landing exactly on the period-start clock -> new value applies one period later.
- Breathe: PRE=0, BSTEP=0, DUTY0=255, CTRL=3, level starting at 0 -> level reads 1,2,...,255,254,... at successive period starts. Direction bit reads 1 after level 255. With level=128, EFF0=127 (pwm[0] high 127 clocks).
- Disable and reset mid-run: clear EN at count 77 -> pwm=000 next clock. Re-enable -> count restarts at 0 and EFF latches immediately. Separately, drive reset_n=0 at count 150 with cs&we active -> the write is ignored and outputs are 0 next clock.

Source files
------------

// File: rtl/rgb_pwm.sv
// Three-channel LED PWM generator with a bus register file and an optional
// hardware breathing fade that scales every channel's duty by a triangle-wave level.
module rgb_pwm #(
  parameter logic [15:0] PRE_RST   = 16'd0,
  parameter logic [15:0] BSTEP_RST = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [2:0]  pwm
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic            en;
  logic            breathe;
  logic [15:0]     pre;
  logic [15:0]     bstep;
  logic [2:0][7:0] duty;
  logic [2:0][7:0] eff;

  logic [15:0]     pre_cnt;
  logic [7:0]      cnt;
  logic [15:0]     bcnt;
  logic [7:0]      level;
  dir_t            dir;
  logic            pflag;

  logic            wr;
  logic            rd;
  logic            tick;
  logic            pstart;
  logic            en_rise;
  logic            bstep_hit;
  logic            breathe_now;
  logic [7:0]      level_nx;
  dir_t            dir_nx;
  logic [2:0][7:0] eff_nx;
  logic [15:0]     prod;
  logic [31:0]     rdata;
  logic            unused_din;

  assign unused_din = ^din[31:16];

  assign wr        = cs & we;
  assign rd        = cs & ~we;
  assign tick      = en && (pre_cnt == pre);
  assign pstart    = tick && (cnt == 8'hFF);
  assign en_rise   = wr && (addr == 3'd0) && din[0] && !en;
  assign bstep_hit = pstart && breathe && (bcnt == bstep);
  // A CTRL write that enables the block also decides whether the first period is scaled.
  assign breathe_now = en_rise ? din[1] : breathe;

  always_comb begin
    level_nx = level;
    dir_nx   = dir;
    if (bstep_hit) begin
      if (dir == DIR_UP) begin
        level_nx = level + 8'd1;
        if (level == 8'd254) dir_nx = DIR_DOWN;
      end else begin
        level_nx = level - 8'd1;
        if (level == 8'd1) dir_nx = DIR_UP;
      end
    end
  end

  // Effective duty uses the level that will be current during the period being latched.
  always_comb begin
    eff_nx = '0;
    prod   = '0;
    for (int c = 0; c < 3; c++) begin
      prod = 16'(duty[c]) * 16'(level_nx);
      eff_nx[c] = breathe_now ? prod[15:8] : duty[c];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0:    rdata = {30'd0, breathe, en};
      3'd1:    rdata = {16'd0, pre};
      3'd2:    rdata = {24'd0, duty[0]};
      3'd3:    rdata = {24'd0, duty[1]};
      3'd4:    rdata = {24'd0, duty[2]};
      3'd5:    rdata = {16'd0, bstep};
      3'd6:    rdata = {22'd0, pflag, dir, level};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en      <= 1'b0;
      breathe <= 1'b0;
      pre     <= PRE_RST;
      bstep   <= BSTEP_RST;
      duty    <= '0;
      eff     <= '0;
      pre_cnt <= '0;
      cnt     <= '0;
      bcnt    <= '0;
      level   <= '0;
      dir     <= DIR_UP;
      pflag   <= 1'b0;
      dout    <= '0;
      pwm     <= '0;
    end else begin
      if (wr) begin
        case (addr)
          3'd0:    begin en <= din[0]; breathe <= din[1]; end
          3'd1:    pre     <= din[15:0];
          3'd2:    duty[0] <= din[7:0];
          3'd3:    duty[1] <= din[7:0];
          3'd4:    duty[2] <= din[7:0];
          3'd5:    bstep   <= din[15:0];
          default: ;
        endcase
      end
      if (rd) dout <= rdata;

      if (!en) begin
        pre_cnt <= '0;
        cnt     <= '0;
        bcnt    <= '0;
      end else begin
        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        if (tick) cnt <= cnt + 8'd1;
        if (pstart && breathe) bcnt <= (bcnt == bstep) ? 16'd0 : bcnt + 16'd1;
      end

      level <= level_nx;
      dir   <= dir_nx;
      if (pstart || en_rise) eff <= eff_nx;

      // A period start in the same cycle as a STATUS read keeps the flag set.
      if (pstart)                   pflag <= 1'b1;
      else if (rd && addr == 3'd6)  pflag <= 1'b0;

      for (int c = 0; c < 3; c++) pwm[c] <= en && (cnt < eff[c]);
    end
  end

endmodule

// File: tb/tb_rgb_pwm.sv
// Randomised bench for rgb_pwm: PWM windows and register reads are checked against
// expectations derived from tick/period arithmetic relative to the enabling write.
module tb_rgb_pwm;

  localparam logic [15:0] PRE_RST_TB   = 16'd5;
  localparam logic [15:0] BSTEP_RST_TB = 16'd9;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [2:0]  pwm;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int win_highs[3];
  int win_rises[3];
  int win_first[3];

  rgb_pwm #(.PRE_RST(PRE_RST_TB), .BSTEP_RST(BSTEP_RST_TB)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we),
    .addr(addr), .din(din), .dout(dout), .pwm(pwm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic int eff_of(input int duty, input int level, input bit br);
    return br ? (duty * level) / 256 : duty;
  endfunction

  // Breathe level after s steps starting from 0 going up.
  function automatic int tri_level(input int s);
    return (s <= 255) ? s : 510 - s;
  endfunction

  function automatic logic [31:0] noisy(input int v, input int width);
    logic [31:0] r;
    logic [31:0] m;
    r = $urandom();
    m = (32'h1 << width) - 32'h1;
    return (r & ~m) | (32'(v) & m);
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; din = $urandom();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a; din = $urandom();
    @(posedge clk); #1;
    cs = 1'b0;
    d = dout;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Collects per-channel high count, number of high runs and first high offset over len samples.
  task automatic sample_win(input int len, input int wr_off, input logic [2:0] wa, input logic [31:0] wd);
    logic [2:0] prev;
    prev = '0;
    for (int c = 0; c < 3; c++) begin
      win_highs[c] = 0; win_rises[c] = 0; win_first[c] = -1;
    end
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (pwm[c] === 1'b1) begin
          win_highs[c]++;
          if (win_first[c] < 0) win_first[c] = i;
          if (!prev[c]) win_rises[c]++;
        end
        prev[c] = (pwm[c] === 1'b1);
      end
      if (i == wr_off) begin cs = 1'b1; we = 1'b1; addr = wa; din = wd; end
      @(posedge clk); #1;
      if (i == wr_off) begin cs = 1'b0; we = 1'b0; end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [31:0] exp;
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pwm !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_pwm_during: got %b, want 000", pwm); end
    n_cmp++; if (dout !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_dout: got %h, want 0", dout); end
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      exp = (a == 1) ? 32'(PRE_RST_TB) : (a == 5) ? 32'(BSTEP_RST_TB) : 32'd0;
      n_cmp++; if (d !== exp) begin n_fail++; $display("[TB] FAIL reset_read addr%0d: got %h, want %h", a, d, exp); end
    end
    n_cmp++; if (pwm !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_pwm_after: got %b, want 000", pwm); end
  endtask

  task automatic test_basic_duty;
    int duty[3];
    int e;
    duty = '{64, 0, 255};
    bus_write(3'd1, noisy(0, 16));
    for (int c = 0; c < 3; c++) bus_write(3'(2 + c), noisy(duty[c], 8));
    bus_write(3'd0, noisy(1, 2));
    e = cyc;
    wait_until(e + 1);
    for (int per = 0; per < 2; per++) begin
      sample_win(256, -1, 3'd0, 32'd0);
      for (int c = 0; c < 3; c++) begin
        n_cmp++; if (win_highs[c] !== duty[c]) begin n_fail++; $display("[TB] FAIL basic_highs p%0d ch%0d: got %0d, want %0d", per, c, win_highs[c], duty[c]); end
        n_cmp++; if (win_first[c] !== (duty[c] != 0 ? 0 : -1)) begin n_fail++; $display("[TB] FAIL basic_first p%0d ch%0d: got %0d, want %0d", per, c, win_first[c], (duty[c] != 0 ? 0 : -1)); end
        n_cmp++; if (win_rises[c] !== (duty[c] != 0 ? 1 : 0)) begin n_fail++; $display("[TB] FAIL basic_runs p%0d ch%0d: got %0d, want %0d", per, c, win_rises[c], (duty[c] != 0 ? 1 : 0)); end
      end
    end
    bus_write(3'd0, 32'd0);
  endtask

  task automatic test_prescaler;
    int duty[3];
    int e;
    duty = '{128, int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
    bus_write(3'd1, noisy(3, 16));
    for (int c = 0; c < 3; c++) bus_write(3'(2 + c), noisy(duty[c], 8));
    bus_write(3'd0, 32'd1);
    e = cyc;
    wait_until(e + 1);
    sample_win(1024, -1, 3'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (win_highs[c] !== duty[c] * 4) begin n_fail++; $display("[TB] FAIL pre_highs ch%0d: got %0d, want %0d", c, win_highs[c], duty[c] * 4); end
      n_cmp++; if (win_rises[c] !== (duty[c] != 0 ? 1 : 0)) begin n_fail++; $display("[TB] FAIL pre_runs ch%0d: got %0d, want %0d", c, win_rises[c], (duty[c] != 0 ? 1 : 0)); end
    end
    bus_write(3'd0, 32'd0);
  endtask

  task automatic test_glitch_free;
    int wo[4];
    int wv[4];
    int e;
    int exp;
    wo = '{99, 254, -1, -1};
    wv = '{200, 120, 0, 0};
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd50);
    bus_write(3'd3, 32'd0);
    bus_write(3'd4, 32'd0);
    bus_write(3'd0, 32'd1);
    e = cyc;
    wait_until(e + 1);
    for (int m = 0; m < 4; m++) begin
      sample_win(256, wo[m], 3'd2, noisy(wv[m], 8));
      // Period m latches whatever DUTY0 held before edge m*256; window m's write lands at m*256+wo+2.
      exp = 50;
      for (int j = 0; j < 4; j++)
        if (wo[j] >= 0 && (j * 256 + wo[j] + 2) < m * 256) exp = wv[j];
      n_cmp++; if (win_highs[0] !== exp) begin n_fail++; $display("[TB] FAIL glitch_highs p%0d: got %0d, want %0d", m, win_highs[0], exp); end
      n_cmp++; if (win_rises[0] !== 1) begin n_fail++; $display("[TB] FAIL glitch_runs p%0d: got %0d, want 1", m, win_rises[0]); end
    end
    bus_write(3'd0, 32'd0);
  endtask

  task automatic test_flag;
    logic [31:0] d;
    int e;
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'd1);
    e = cyc;
    wait_until(e + 99);
    bus_read(3'd6, d);
    wait_until(e + 255);
    bus_read(3'd6, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL flag_before_start: got %h, want 00000000", d); end
    bus_read(3'd6, d);
    n_cmp++; if (d !== 32'h200) begin n_fail++; $display("[TB] FAIL flag_set_wins: got %h, want 00000200", d); end
    bus_read(3'd6, d);
    n_cmp++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL flag_cleared: got %h, want 00000000", d); end
    bus_write(3'd0, 32'd0);
  endtask

  task automatic test_disable;
    int d1;
    int e;
    int bad;
    logic [2:0] exp;
    d1 = $urandom_range(1, 254);
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd255);
    bus_write(3'd3, noisy(d1, 8));
    bus_write(3'd4, 32'd0);
    bus_write(3'd0, 32'd1);
    e = cyc;
    wait_until(e + 76);
    bus_write(3'd0, 32'd0);
    exp = {1'b0, (76 < d1), 1'b1};
    n_cmp++; if (pwm !== exp) begin n_fail++; $display("[TB] FAIL disable_last_active: got %b, want %b", pwm, exp); end
    @(posedge clk); #1;
    n_cmp++; if (pwm !== 3'b000) begin n_fail++; $display("[TB] FAIL disable_next_clock: got %b, want 000", pwm); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm !== 3'b000) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL disable_held: got %0d high samples, want 0", bad); end
    bus_write(3'd2, 32'd30);
    bus_write(3'd0, 32'd1);
    e = cyc;
    wait_until(e + 1);
    sample_win(256, -1, 3'd0, 32'd0);
    n_cmp++; if (win_highs[0] !== 30) begin n_fail++; $display("[TB] FAIL reenable_highs: got %0d, want 30", win_highs[0]); end
    n_cmp++; if (win_first[0] !== 0) begin n_fail++; $display("[TB] FAIL reenable_first: got %0d, want 0", win_first[0]); end
    n_cmp++; if (win_highs[1] !== d1) begin n_fail++; $display("[TB] FAIL reenable_ch1: got %0d, want %0d", win_highs[1], d1); end
    bus_write(3'd0, 32'd0);
  endtask

  task automatic test_random;
    int duty[3];
    int p;
    int e;
    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(0, 2);
      for (int c = 0; c < 3; c++) duty[c] = $urandom_range(0, 255);
      bus_write(3'd1, noisy(p, 16));
      for (int c = 0; c < 3; c++) bus_write(3'(2 + c), noisy(duty[c], 8));
      bus_write(3'd0, noisy(1, 2));
      e = cyc;
      wait_until(e + 1);
      sample_win(256 * (p + 1), -1, 3'd0, 32'd0);
      for (int c = 0; c < 3; c++) begin
        n_cmp++; if (win_highs[c] !== duty[c] * (p + 1)) begin n_fail++; $display("[TB] FAIL rand_highs r%0d ch%0d: got %0d, want %0d", r, c, win_highs[c], duty[c] * (p + 1)); end
        n_cmp++; if (win_first[c] !== (duty[c] != 0 ? 0 : -1)) begin n_fail++; $display("[TB] FAIL rand_first r%0d ch%0d: got %0d, want %0d", r, c, win_first[c], (duty[c] != 0 ? 0 : -1)); end
      end
      bus_write(3'd0, 32'd0);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] d;
    int e;
    bus_write(3'd1, 32'd0);
    for (int c = 0; c < 3; c++) bus_write(3'(2 + c), 32'd255);
    bus_write(3'd0, 32'd1);
    e = cyc;
    wait_until(e + 149);
    reset_n = 1'b0; cs = 1'b1; we = 1'b1; addr = 3'd2; din = 32'h77;
    @(posedge clk); #1;
    n_cmp++; if (pwm !== 3'b000) begin n_fail++; $display("[TB] FAIL midreset_pwm: got %b, want 000", pwm); end
    n_cmp++; if (dout !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_dout: got %h, want 0", dout); end
    cs = 1'b0; we = 1'b0; reset_n = 1'b1;
    bus_read(3'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_write_ignored: got %h, want 0", d); end
    bus_read(3'd1, d);
    n_cmp++; if (d !== 32'(PRE_RST_TB)) begin n_fail++; $display("[TB] FAIL midreset_pre: got %h, want %h", d, 32'(PRE_RST_TB)); end
    bus_read(3'd0, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_ctrl: got %h, want 0", d); end
    n_cmp++; if (pwm !== 3'b000) begin n_fail++; $display("[TB] FAIL midreset_pwm_after: got %b, want 000", pwm); end
  endtask

  task automatic test_breathe;
    logic [31:0] d;
    int e;
    int exp;
    bus_write(3'd1, 32'd0);
    bus_write(3'd5, noisy(0, 16));
    bus_write(3'd2, 32'd255);
    bus_write(3'd0, noisy(3, 2));
    e = cyc;
    for (int m = 1; m <= 257; m++) begin
      if (m == 128 || m == 200) begin
        wait_until(e + m * 256 + 1);
        sample_win(256, -1, 3'd0, 32'd0);
        exp = eff_of(255, tri_level(m), 1'b1);
        n_cmp++; if (win_highs[0] !== exp) begin n_fail++; $display("[TB] FAIL breathe_highs lvl%0d: got %0d, want %0d", tri_level(m), win_highs[0], exp); end
      end else begin
        wait_until(e + m * 256 + 127);
        bus_read(3'd6, d);
        exp = tri_level(m);
        n_cmp++; if (int'(d[7:0]) !== exp) begin n_fail++; $display("[TB] FAIL breathe_level step%0d: got %0d, want %0d", m, d[7:0], exp); end
        if (m != 255) begin
          n_cmp++; if (d[8] !== (m > 255)) begin n_fail++; $display("[TB] FAIL breathe_dir step%0d: got %b, want %b", m, d[8], (m > 255)); end
        end
      end
    end
    bus_write(3'd0, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    test_reset();
    test_basic_duty();
    test_prescaler();
    test_glitch_free();
    test_flag();
    test_disable();
    test_random();
    test_reset_mid_run();
    test_breathe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
